// File: rtl/mmu_array_top.sv
// N x N signed matrix multiply: A/B streamed one column/row per beat as rank-1
// updates into an accumulator array, then C drained one row per handshake.

module mmu_row #(
  parameter int N    = 2,
  parameter int DW   = 8,
  parameter int ACCW = 2*DW+$clog2(N)
) (
  input  logic                      D_CLK,
  input  logic                      D_OFF,
  input  logic                      clr,
  input  logic                      en,
  input  logic signed [DW-1:0]      a_el,
  input  logic [N-1:0][DW-1:0]      b_vec,
  output logic [N-1:0][ACCW-1:0]    acc
);
  logic [N-1:0][ACCW-1:0] acc_q, acc_d;

  for (genvar j = 0; j < N; j++) begin : g_mac
    logic signed [2*DW-1:0] prod;
    assign prod = a_el * $signed(b_vec[j]);

    always_comb begin
      acc_d[j] = acc_q[j];
      if (clr)     acc_d[j] = '0;
      else if (en) acc_d[j] = acc_q[j] + ACCW'(prod); // sign-extending cast
    end
  end

  always_ff @(posedge D_CLK or negedge D_OFF) begin
    if (!D_OFF) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;
endmodule

module mmu_array_top #(
  parameter int N    = 2,
  parameter int DW   = 8,
  parameter int ACCW = 2*DW+$clog2(N)
) (
  input  logic              D_CLK,
  input  logic              D_OFF,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*DW-1:0]   a_col,
  input  logic [N*DW-1:0]   b_row,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*ACCW-1:0] OUT,
  output logic              LED_0,
  output logic              LED_1,
  output logic              LED_2
);
  localparam int KW = $clog2(N);
  localparam logic [KW-1:0] LAST = KW'(N-1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d, r_q, r_d;
  logic            done_q, done_d, err_q, err_d;
  logic            clr, acc_en;

  logic [N-1:0][DW-1:0]           a_vec, b_vec;
  logic [N-1:0][N-1:0][ACCW-1:0]  acc_all;

  assign a_vec = a_col;
  assign b_vec = b_row;

  for (genvar i = 0; i < N; i++) begin : g_row
    mmu_row #(.N(N), .DW(DW), .ACCW(ACCW)) u_row (
      .D_CLK (D_CLK),
      .D_OFF (D_OFF),
      .clr   (clr),
      .en    (acc_en),
      .a_el  (a_vec[i]),
      .b_vec (b_vec),
      .acc   (acc_all[i])
    );
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    r_d     = r_q;
    done_d  = done_q;
    err_d   = err_q;
    clr     = 1'b0;
    acc_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          clr     = 1'b1;
          k_d     = '0;
          done_d  = 1'b0;
        end
      end
      LOAD: begin
        if (start) err_d = 1'b1;
        if (in_valid) begin
          acc_en = 1'b1;
          if (k_q == LAST) begin
            state_d = DRAIN;
            k_d     = '0;
            r_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // start here is an error even on the final row handshake
        if (start) err_d = 1'b1;
        if (out_ready) begin
          if (r_q == LAST) begin
            state_d = IDLE;
            r_d     = '0;
            done_d  = 1'b1;
          end else begin
            r_d = r_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge D_CLK or negedge D_OFF) begin
    if (!D_OFF) begin
      state_q <= IDLE;
      k_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      r_q     <= r_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Accumulators are frozen during DRAIN, so OUT is stable under backpressure.
  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == DRAIN);
  assign OUT       = out_valid ? acc_all[r_q] : '0;
  assign LED_0     = (state_q != IDLE);
  assign LED_1     = done_q;
  assign LED_2     = err_q;
endmodule

// File: tb/tb_mmu_array_top.sv
// Randomized scoreboard bench for mmu_array_top: reference C = A*B per transaction,
// rows queued at issue and checked by an independent output monitor.

module tb_mmu_array_top;
  localparam int N    = 2;
  localparam int DW   = 8;
  localparam int ACCW = 17;

  logic              D_CLK = 1'b0;
  logic              D_OFF = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N*DW-1:0]   a_col = '0;
  logic [N*DW-1:0]   b_row = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [N*ACCW-1:0] OUT;
  logic              LED_0, LED_1, LED_2;

  mmu_array_top #(.N(N), .DW(DW), .ACCW(ACCW)) dut (
    .D_CLK(D_CLK), .D_OFF(D_OFF), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .a_col(a_col), .b_row(b_row), .out_valid(out_valid),
    .out_ready(out_ready), .OUT(OUT), .LED_0(LED_0), .LED_1(LED_1), .LED_2(LED_2)
  );

  always #5 D_CLK = ~D_CLK;

  int n_vec = 0;
  int n_err = 0;
  logic [N*ACCW-1:0] exp_q[$];
  int A[N][N];
  int B[N][N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout expected completion at %0t", name, $time);
  endtask

  // Output monitor: every valid row must match the oldest expected row.
  always @(negedge D_CLK) begin
    if (!D_OFF) begin
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_row");
      end else begin
        chk("row", 64'(OUT), 64'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end else begin
      chk("out_zero_idle", 64'(OUT), 64'd0);
    end
  end

  task automatic push_expected();
    logic [N*ACCW-1:0] row;
    int c;
    for (int r = 0; r < N; r++) begin
      row = '0;
      for (int j = 0; j < N; j++) begin
        c = 0;
        for (int k = 0; k < N; k++) c += A[r][k] * B[k][j];
        row[j*ACCW +: ACCW] = ACCW'(c);
      end
      exp_q.push_back(row);
    end
  endtask

  task automatic send_beats(input int gap, input bit rgap, input bit start_mid);
    int g, cyc;
    start = 1'b1;
    @(posedge D_CLK); #1;
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      g = rgap ? int'($urandom_range(0, gap)) : gap;
      repeat (g) begin
        in_valid = 1'b0;
        a_col = 16'($urandom);
        b_row = 16'($urandom);
        @(posedge D_CLK); #1;
      end
      in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        a_col[i*DW +: DW] = 8'(A[i][k]);
        b_row[i*DW +: DW] = 8'(B[k][i]);
      end
      if (start_mid && k == 1) start = 1'b1;
      cyc = 0;
      while (!in_ready && cyc < 20) begin
        @(posedge D_CLK); #1;
        cyc++;
      end
      if (!in_ready) fail_now("in_ready_wait");
      @(posedge D_CLK); #1;
      start = 1'b0;
    end
    // garbage beats offered during DRAIN must be ignored
    a_col = 16'($urandom);
    b_row = 16'($urandom);
  endtask

  task automatic run_mult(input int gap, input bit rgap, input int stall,
                          input bit rnd_rdy, input bit start_mid);
    int cyc;
    push_expected();
    send_beats(gap, rgap, start_mid);
    cyc = 0;
    while (LED_0 && cyc < 200) begin
      out_ready = (cyc < stall) ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      @(posedge D_CLK); #1;
      cyc++;
    end
    if (LED_0) fail_now("drain_wait");
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("led1_done", {63'd0, LED_1}, 64'd1);
    chk("led0_idle", {63'd0, LED_0}, 64'd0);
  endtask

  task automatic set_ab(input int a00, a01, a10, a11, b00, b01, b10, b11);
    A[0][0] = a00; A[0][1] = a01; A[1][0] = a10; A[1][1] = a11;
    B[0][0] = b00; B[0][1] = b01; B[1][0] = b10; B[1][1] = b11;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out", 64'(OUT), 64'd0);
    chk("rst_leds", {61'd0, LED_0, LED_1, LED_2}, 64'd0);
    repeat (2) @(posedge D_CLK);
    #1 D_OFF = 1'b1;

    // basic product, no gaps, no backpressure
    set_ab(1, 2, 3, 4, 5, 6, 7, 8);
    run_mult(0, 1'b0, 0, 1'b0, 1'b0);
    chk("led2_clean", {63'd0, LED_2}, 64'd0);

    // most negative operands: 2*16384 without wrap
    set_ab(-128, -128, -128, -128, -128, -128, -128, -128);
    run_mult(0, 1'b0, 0, 1'b0, 1'b0);

    // three stall cycles on the first row
    set_ab(1, 2, 3, 4, 5, 6, 7, 8);
    run_mult(0, 1'b0, 3, 1'b0, 1'b0);

    // two idle cycles before each beat
    run_mult(2, 1'b0, 0, 1'b0, 1'b0);

    // start during LOAD: result unchanged, error latched
    run_mult(0, 1'b0, 0, 1'b0, 1'b1);
    chk("led2_set", {63'd0, LED_2}, 64'd1);

    // randomized operands, gaps and backpressure
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          A[i][j] = int'($urandom_range(0, 255)) - 128;
          B[i][j] = int'($urandom_range(0, 255)) - 128;
        end
      run_mult(3, 1'b1, 0, 1'b1, 1'b0);
    end
    chk("led2_sticky", {63'd0, LED_2}, 64'd1);

    // reset in DRAIN after row 0 has left
    set_ab(1, 2, 3, 4, 5, 6, 7, 8);
    push_expected();
    send_beats(0, 1'b0, 1'b0);
    out_ready = 1'b1;
    @(posedge D_CLK); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #2 D_OFF = 1'b0;
    #1;
    chk("abort_out", 64'(OUT), 64'd0);
    chk("abort_vld_rdy", {62'd0, out_valid, in_ready}, 64'd0);
    chk("abort_leds", {61'd0, LED_0, LED_1, LED_2}, 64'd0);
    chk("abort_pending_rows", 64'(exp_q.size()), 64'd1);
    exp_q.delete();
    @(posedge D_CLK); #1;
    D_OFF = 1'b1;

    // identity A right after reset release
    set_ab(1, 0, 0, 1, 5, 6, 7, 8);
    run_mult(0, 1'b0, 0, 1'b0, 1'b0);
    chk("led2_after_rst", {63'd0, LED_2}, 64'd0);

    repeat (3) @(posedge D_CLK);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mmu_array_top.md
MMU_ARRAY_TOP -- requirements
Module: mmu_array_top

Interface
REQ-001 Parameter N, default 2: matrix dimension (N x N operands), N >= 2.
REQ-002 Parameter DW, default 8: signed operand element width.
REQ-003 Parameter ACCW, default 2*DW+$clog2(N): signed accumulator / result element width.
REQ-004 D_CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 D_OFF  in  1  reset; asynchronous, active-low.
REQ-006 start  in  1  begin new multiply; sampled each cycle.
REQ-007 in_valid  in  1  operand beat valid.
REQ-008 in_ready  out  1  block accepts an operand beat.
REQ-009 a_col  in  N*DW  column k of A; element i at [i*DW +: DW].
REQ-010 b_row  in  N*DW  row k of B; element j at [j*DW +: DW].
REQ-011 out_valid  out  1  result row valid.
REQ-012 out_ready  in  1  downstream accepts result row.
REQ-013 OUT  out  N*ACCW  result row r of C; element j at [j*ACCW +: ACCW].
REQ-014 LED_0  out  1  busy (LOAD or DRAIN).
REQ-015 LED_1  out  1  done; sticky until next accepted start.
REQ-016 LED_2  out  1  error; sticky until reset.

Function
REQ-017 FSM states IDLE, LOAD, DRAIN; reset state IDLE.
REQ-018 IDLE: start=1 -> LOAD next cycle, all N*N accumulators cleared, beat counter k=0, LED_1 cleared.
REQ-019 in_ready=1 only in LOAD; a beat transfers on in_valid && in_ready; in_valid gaps allowed, no timeout.
REQ-020 Each transfer: C[i][j] += a_col[i]*b_row[j] for all i,j (signed, full-precision product sign-extended to ACCW), registered that edge; k increments.
REQ-021 Transfer with k=N-1 -> DRAIN next cycle, row index r=0; out_valid=1 in the first DRAIN cycle (latency: 1 cycle after last beat).
REQ-022 DRAIN: out_valid=1, OUT = row r; row transfers on out_valid && out_ready; OUT and out_valid held stable while out_ready=0.
REQ-023 Row transfer with r=N-1 -> IDLE next cycle, LED_1 set, out_valid=0.
REQ-024 Accumulation wraps modulo 2^ACCW; no saturation (default ACCW cannot overflow for DW-bit signed operands summed N times).
REQ-025 start=1 in LOAD or DRAIN: ignored for datapath/FSM, LED_2 set.
REQ-026 start=1 in same cycle as last row transfer: ignored and LED_2 set (state is still DRAIN).
REQ-027 in_valid in IDLE/DRAIN: ignored, no accumulation, no error.
REQ-028 LED_0 = 1 exactly when state is LOAD or DRAIN.
REQ-029 OUT = 0 whenever out_valid=0.

Reset
REQ-030 D_OFF low asynchronously forces: state IDLE, k=0, r=0, all accumulators 0, in_ready=0, out_valid=0, OUT=0, LED_0=0, LED_1=0, LED_2=0.
REQ-031 Reset mid-LOAD or mid-DRAIN aborts the operation; no partial result emitted after release.
REQ-032 First start honoured on the first rising edge after D_OFF deasserts.

Verification (N=2, DW=8, ACCW=17)
REQ-033 A=[[1,2],[3,4]], B=[[5,6],[7,8]]: beats (a_col={1,3},b_row={5,6}), ({2,4},{7,8}), out_ready=1 -> rows {19,22} then {43,50}, LED_1=1, LED_0=0.
REQ-034 All A and B elements -128 -> every C element 32768 (0x08000), no wrap.
REQ-035 Same as REQ-033 with out_ready=0 for 3 cycles in DRAIN -> OUT holds {19,22} stable, out_valid=1 throughout, then completes normally.
REQ-036 in_valid deasserted 2 cycles between beats -> identical result to REQ-033.
REQ-037 start pulsed during LOAD -> result unchanged, LED_2=1 and remains 1 until D_OFF low.
REQ-038 D_OFF low during DRAIN after row 0 -> all outputs 0 immediately; new start + A=I, B=[[5,6],[7,8]] -> rows {5,6},{7,8}.
